// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI4-Stream output among NUM_S sources.
// Only the grant decision is registered; the payload path is a combinational mux.
module axis_packet_arbiter #(
    parameter int unsigned NUM_S                = 4,
    parameter int unsigned DATA_BYTES           = 4,
    parameter int unsigned TID_WIDTH            = 1,
    parameter int unsigned TDEST_WIDTH          = 1,
    parameter int unsigned TUSER_WIDTH_PER_BYTE = 1
) (
    input  logic                                                aclk,
    input  logic                                                aresetn,
    input  logic [NUM_S-1:0]                                    s_enable,
    input  logic [NUM_S-1:0]                                    s_axis_tvalid,
    output logic [NUM_S-1:0]                                    s_axis_tready,
    input  logic [NUM_S*DATA_BYTES*8-1:0]                       s_axis_tdata,
    input  logic [NUM_S*DATA_BYTES-1:0]                         s_axis_tstrb,
    input  logic [NUM_S*DATA_BYTES-1:0]                         s_axis_tkeep,
    input  logic [NUM_S-1:0]                                    s_axis_tlast,
    input  logic [NUM_S*TID_WIDTH-1:0]                          s_axis_tid,
    input  logic [NUM_S*TDEST_WIDTH-1:0]                        s_axis_tdest,
    input  logic [NUM_S*DATA_BYTES*TUSER_WIDTH_PER_BYTE-1:0]    s_axis_tuser,
    output logic                                                m_axis_tvalid,
    input  logic                                                m_axis_tready,
    output logic [DATA_BYTES*8-1:0]                             m_axis_tdata,
    output logic [DATA_BYTES-1:0]                               m_axis_tstrb,
    output logic [DATA_BYTES-1:0]                               m_axis_tkeep,
    output logic                                                m_axis_tlast,
    output logic [TID_WIDTH-1:0]                                m_axis_tid,
    output logic [TDEST_WIDTH-1:0]                              m_axis_tdest,
    output logic [DATA_BYTES*TUSER_WIDTH_PER_BYTE-1:0]          m_axis_tuser,
    output logic [$clog2(NUM_S)-1:0]                            grant_idx,
    output logic                                                grant_active,
    output logic                                                pkt_done
);

    localparam int unsigned DW = DATA_BYTES * 8;
    localparam int unsigned SW = DATA_BYTES;
    localparam int unsigned UW = DATA_BYTES * TUSER_WIDTH_PER_BYTE;
    localparam int unsigned GW = $clog2(NUM_S);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q, last_d;
    logic            done_q, done_d;

    logic [NUM_S-1:0] req;
    logic [GW-1:0]    winner;
    logic             win_found;
    int unsigned      cand;

    logic             sel_tvalid;
    logic             sel_tlast;
    logic [DW-1:0]    sel_tdata;
    logic [SW-1:0]    sel_tstrb;
    logic [SW-1:0]    sel_tkeep;
    logic [TID_WIDTH-1:0]   sel_tid;
    logic [TDEST_WIDTH-1:0] sel_tdest;
    logic [UW-1:0]    sel_tuser;
    logic             busy;

    assign req  = s_axis_tvalid & s_enable;
    assign busy = (state_q == BUSY);

    // Rotating search starting just after the previous owner gives round-robin order.
    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        cand      = 0;
        for (int unsigned k = 1; k <= NUM_S; k++) begin
            cand = (32'(last_q) + k) % NUM_S;
            if (!win_found && req[cand]) begin
                winner    = GW'(cand);
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        sel_tvalid = 1'b0;
        sel_tlast  = 1'b0;
        sel_tdata  = '0;
        sel_tstrb  = '0;
        sel_tkeep  = '0;
        sel_tid    = '0;
        sel_tdest  = '0;
        sel_tuser  = '0;
        for (int unsigned i = 0; i < NUM_S; i++) begin
            if (grant_q == GW'(i)) begin
                sel_tvalid = s_axis_tvalid[i];
                sel_tlast  = s_axis_tlast[i];
                sel_tdata  = s_axis_tdata[i*DW +: DW];
                sel_tstrb  = s_axis_tstrb[i*SW +: SW];
                sel_tkeep  = s_axis_tkeep[i*SW +: SW];
                sel_tid    = s_axis_tid[i*TID_WIDTH +: TID_WIDTH];
                sel_tdest  = s_axis_tdest[i*TDEST_WIDTH +: TDEST_WIDTH];
                sel_tuser  = s_axis_tuser[i*UW +: UW];
            end
        end
    end

    always_comb begin
        s_axis_tready = '0;
        for (int unsigned i = 0; i < NUM_S; i++) begin
            s_axis_tready[i] = busy && (grant_q == GW'(i)) && m_axis_tready;
        end
    end

    assign m_axis_tvalid = busy & sel_tvalid;
    assign m_axis_tlast  = busy & sel_tlast;
    assign m_axis_tdata  = sel_tdata;
    assign m_axis_tstrb  = sel_tstrb;
    assign m_axis_tkeep  = sel_tkeep;
    assign m_axis_tid    = sel_tid;
    assign m_axis_tdest  = sel_tdest;
    assign m_axis_tuser  = sel_tuser;

    assign grant_idx    = grant_q;
    assign grant_active = busy;
    assign pkt_done     = done_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d = winner;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (sel_tvalid && m_axis_tready && sel_tlast) begin
                    last_d  = grant_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(NUM_S - 1);
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter: per-cycle check against an owner/queue model,
// plus literal expectations on observed beat order, grant order and payload fields.
module tb_axis_packet_arbiter;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  keep;
        logic        last;
        logic [3:0]  id;
        logic [1:0]  dest;
        logic [3:0]  user;
    } beat_t;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic [3:0]   s_enable;
    logic [3:0]   s_tvalid;
    logic [3:0]   s_tready;
    logic [127:0] s_tdata;
    logic [15:0]  s_tstrb;
    logic [15:0]  s_tkeep;
    logic [3:0]   s_tlast;
    logic [15:0]  s_tid;
    logic [7:0]   s_tdest;
    logic [15:0]  s_tuser;
    logic         m_tvalid;
    logic         m_tready;
    logic [31:0]  m_tdata;
    logic [3:0]   m_tstrb;
    logic [3:0]   m_tkeep;
    logic         m_tlast;
    logic [3:0]   m_tid;
    logic [1:0]   m_tdest;
    logic [3:0]   m_tuser;
    logic [1:0]   grant_idx;
    logic         grant_active;
    logic         pkt_done;

    always #5 aclk = ~aclk;

    axis_packet_arbiter #(
        .NUM_S(4),
        .DATA_BYTES(4),
        .TID_WIDTH(4),
        .TDEST_WIDTH(2),
        .TUSER_WIDTH_PER_BYTE(1)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .s_enable(s_enable),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tdata(s_tdata),
        .s_axis_tstrb(s_tstrb),
        .s_axis_tkeep(s_tkeep),
        .s_axis_tlast(s_tlast),
        .s_axis_tid(s_tid),
        .s_axis_tdest(s_tdest),
        .s_axis_tuser(s_tuser),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tdata(m_tdata),
        .m_axis_tstrb(m_tstrb),
        .m_axis_tkeep(m_tkeep),
        .m_axis_tlast(m_tlast),
        .m_axis_tid(m_tid),
        .m_axis_tdest(m_tdest),
        .m_axis_tuser(m_tuser),
        .grant_idx(grant_idx),
        .grant_active(grant_active),
        .pkt_done(pkt_done)
    );

    int checks = 0;
    int errors = 0;

    beat_t mem [4][32];
    int    rd [4];
    int    wr [4];
    logic [3:0] fire;

    beat_t out_log [64];
    int    out_cyc [64];
    int    n_out;
    int    glog [16];
    int    n_g;
    int    n_done;
    int    cyc;

    int    mdl_owner;
    int    mdl_last;
    logic  mdl_done;
    logic  prev_ga;
    logic [3:0] req;
    logic  found;
    beat_t cb;
    beat_t ob;

    logic [31:0] exp_d [8];
    int          exp_g [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic beat_t cur_beat(input int i);
        if (rd[i] < wr[i]) return mem[i][rd[i]];
        return '0;
    endfunction

    function automatic beat_t mk(input logic [31:0] d, input logic l);
        beat_t b;
        b = '0;
        b.data = d;
        b.strb = 4'hF;
        b.keep = 4'hF;
        b.last = l;
        return b;
    endfunction

    task automatic drive();
        beat_t b;
        for (int i = 0; i < 4; i++) begin
            b = cur_beat(i);
            s_tvalid[i]          = (rd[i] < wr[i]);
            s_tlast[i]           = b.last;
            s_tdata[i*32 +: 32]  = b.data;
            s_tstrb[i*4 +: 4]    = b.strb;
            s_tkeep[i*4 +: 4]    = b.keep;
            s_tid[i*4 +: 4]      = b.id;
            s_tdest[i*2 +: 2]    = b.dest;
            s_tuser[i*4 +: 4]    = b.user;
        end
    endtask

    task automatic push(input int src, input beat_t b);
        mem[src][wr[src]] = b;
        wr[src]++;
        drive();
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (fire[i] && rd[i] < wr[i]) rd[i]++;
        end
        cyc++;
        drive();
    endtask

    task automatic clear_logs();
        n_out  = 0;
        n_g    = 0;
        n_done = 0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd[i] = 0;
            wr[i] = 0;
        end
        drive();
        tick();
        tick();
        aresetn  = 1'b1;
        s_enable = 4'hF;
        m_tready = 1'b1;
        clear_logs();
    endtask

    task automatic wait_out(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (n_out < n && k < budget) begin
            tick();
            k++;
        end
        chk(name, 64'(n_out), 64'(n));
    endtask

    task automatic check_data(input string name, input int n);
        for (int i = 0; i < n; i++) chk(name, 64'(out_log[i].data), 64'(exp_d[i]));
    endtask

    task automatic check_grants(input string name, input int n);
        chk({name, "_count"}, 64'(n_g), 64'(n));
        for (int i = 0; i < n; i++) chk(name, 64'(glog[i]), 64'(exp_g[i]));
    endtask

    // Model: owner is -1 when nobody holds the output; decisions take effect at the next edge.
    always @(negedge aclk) begin
        if (!aresetn) begin
            chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
            chk("rst_m_tlast", 64'(m_tlast), 64'd0);
            chk("rst_s_tready", 64'(s_tready), 64'd0);
            chk("rst_grant_active", 64'(grant_active), 64'd0);
            chk("rst_grant_idx", 64'(grant_idx), 64'd0);
            chk("rst_pkt_done", 64'(pkt_done), 64'd0);
            mdl_owner = -1;
            mdl_last  = 3;
            mdl_done  = 1'b0;
            fire      = '0;
            prev_ga   = 1'b0;
        end else begin
            chk("pkt_done", 64'(pkt_done), 64'(mdl_done));
            mdl_done = 1'b0;
            if (mdl_owner < 0) begin
                chk("idle_grant_active", 64'(grant_active), 64'd0);
                chk("idle_m_tvalid", 64'(m_tvalid), 64'd0);
                chk("idle_s_tready", 64'(s_tready), 64'd0);
                req   = s_tvalid & s_enable;
                found = 1'b0;
                for (int k = 1; k <= 4; k++) begin
                    if (!found && req[(mdl_last + k) % 4]) begin
                        mdl_owner = (mdl_last + k) % 4;
                        found     = 1'b1;
                    end
                end
            end else begin
                cb = cur_beat(mdl_owner);
                chk("busy_grant_active", 64'(grant_active), 64'd1);
                chk("busy_grant_idx", 64'(grant_idx), 64'(mdl_owner));
                chk("busy_m_tvalid", 64'(m_tvalid), 64'(s_tvalid[mdl_owner]));
                chk("busy_s_tready", 64'(s_tready), m_tready ? 64'(4'b0001 << mdl_owner) : 64'd0);
                if (s_tvalid[mdl_owner]) begin
                    chk("m_tdata", 64'(m_tdata), 64'(cb.data));
                    chk("m_tlast", 64'(m_tlast), 64'(cb.last));
                    chk("m_tstrb", 64'(m_tstrb), 64'(cb.strb));
                    chk("m_tkeep", 64'(m_tkeep), 64'(cb.keep));
                    chk("m_tid", 64'(m_tid), 64'(cb.id));
                    chk("m_tdest", 64'(m_tdest), 64'(cb.dest));
                    chk("m_tuser", 64'(m_tuser), 64'(cb.user));
                    if (m_tready && cb.last) begin
                        mdl_done  = 1'b1;
                        mdl_last  = mdl_owner;
                        mdl_owner = -1;
                    end
                end
            end
            fire = s_tvalid & s_tready;
            if (m_tvalid && m_tready && n_out < 64) begin
                ob.data = m_tdata;
                ob.strb = m_tstrb;
                ob.keep = m_tkeep;
                ob.last = m_tlast;
                ob.id   = m_tid;
                ob.dest = m_tdest;
                ob.user = m_tuser;
                out_log[n_out] = ob;
                out_cyc[n_out] = cyc;
                n_out++;
            end
            if (grant_active && !prev_ga && n_g < 16) begin
                glog[n_g] = int'(grant_idx);
                n_g++;
            end
            if (pkt_done) n_done++;
            prev_ga = grant_active;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end of the directed sequence");
        $fatal(1, "watchdog expired");
    end

    initial begin
        aresetn  = 1'b0;
        s_enable = 4'hF;
        m_tready = 1'b1;
        fire     = '0;
        cyc      = 0;
        for (int i = 0; i < 4; i++) begin
            rd[i] = 0;
            wr[i] = 0;
        end
        clear_logs();
        drive();
        tick();
        tick();
        tick();
        chk("reset_grant_idx", 64'(grant_idx), 64'd0);
        chk("reset_grant_active", 64'(grant_active), 64'd0);
        chk("reset_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("reset_s_tready", 64'(s_tready), 64'd0);
        chk("reset_pkt_done", 64'(pkt_done), 64'd0);
        aresetn = 1'b1;
        clear_logs();

        // Two 3-beat packets from sources 0 and 2.
        push(0, mk(32'hA0, 1'b0)); push(0, mk(32'hA1, 1'b0)); push(0, mk(32'hA2, 1'b1));
        push(2, mk(32'hC0, 1'b0)); push(2, mk(32'hC1, 1'b0)); push(2, mk(32'hC2, 1'b1));
        wait_out(6, 40, "t1_beats");
        tick();
        tick();
        exp_d = '{32'hA0, 32'hA1, 32'hA2, 32'hC0, 32'hC1, 32'hC2, 32'h0, 32'h0};
        check_data("t1_data", 6);
        exp_g = '{0, 2, 0, 0, 0, 0, 0, 0};
        check_grants("t1_grant", 2);
        chk("t1_pkt_done_count", 64'(n_done), 64'd2);
        chk("t1_idle_gap", 64'(out_cyc[3] - out_cyc[2]), 64'd2);

        // All four sources stream single-beat packets.
        do_reset();
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < 4; i++) push(i, mk(32'(i * 16 + j), 1'b1));
        wait_out(8, 60, "t2_beats");
        tick();
        tick();
        exp_d = '{32'h00, 32'h10, 32'h20, 32'h30, 32'h01, 32'h11, 32'h21, 32'h31};
        check_data("t2_data", 8);
        exp_g = '{0, 1, 2, 3, 0, 1, 2, 3};
        check_grants("t2_grant", 8);
        for (int i = 1; i < 8; i++) chk("t2_beat_spacing", 64'(out_cyc[i] - out_cyc[i-1]), 64'd2);
        chk("t2_pkt_done_count", 64'(n_done), 64'd8);

        // Source 1 under output backpressure, others queued behind it.
        do_reset();
        for (int j = 0; j < 4; j++) push(1, mk(32'h10 + 32'(j), j == 3));
        tick();
        push(0, mk(32'h00, 1'b1));
        push(3, mk(32'h30, 1'b1));
        m_tready = 1'b1; tick();
        m_tready = 1'b0; tick();
        m_tready = 1'b0; tick();
        m_tready = 1'b1;
        wait_out(6, 40, "t3_beats");
        tick();
        exp_d = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h30, 32'h00, 32'h0, 32'h0};
        check_data("t3_data", 6);
        exp_g = '{1, 3, 0, 0, 0, 0, 0, 0};
        check_grants("t3_grant", 3);

        // Enable mask excludes source 2; source 0 is disabled mid-packet.
        do_reset();
        s_enable = 4'b1011;
        for (int j = 0; j < 4; j++) push(0, mk(32'h00 + 32'(j), j == 3));
        push(1, mk(32'h10, 1'b1));
        push(2, mk(32'h20, 1'b1));
        push(3, mk(32'h30, 1'b1));
        tick();
        tick();
        tick();
        s_enable = 4'b1010;
        wait_out(6, 40, "t4_beats");
        for (int i = 0; i < 6; i++) tick();
        exp_d = '{32'h00, 32'h01, 32'h02, 32'h03, 32'h10, 32'h30, 32'h0, 32'h0};
        check_data("t4_data", 6);
        exp_g = '{0, 1, 3, 0, 0, 0, 0, 0};
        check_grants("t4_grant", 3);
        chk("t4_src2_stalled", 64'(wr[2] - rd[2]), 64'd1);
        chk("t4_idle_when_disabled", 64'(grant_active), 64'd0);

        // Reset on beat 2 of a 5-beat packet from source 0.
        do_reset();
        for (int j = 0; j < 5; j++) push(0, mk(32'h50 + 32'(j), j == 4));
        push(1, mk(32'h60, 1'b1));
        wait_out(2, 20, "t5_pre_beats");
        aresetn = 1'b0;
        rd[0] = wr[0];
        drive();
        @(negedge aclk);
        #1;
        chk("t5_rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("t5_rst_s_tready", 64'(s_tready), 64'd0);
        chk("t5_rst_grant_active", 64'(grant_active), 64'd0);
        tick();
        aresetn = 1'b1;
        clear_logs();
        push(0, mk(32'h5A, 1'b1));
        wait_out(2, 20, "t5_beats");
        tick();
        exp_d = '{32'h5A, 32'h60, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        check_data("t5_data", 2);
        exp_g = '{0, 1, 0, 0, 0, 0, 0, 0};
        check_grants("t5_grant", 2);

        // Sideband fields from source 3 must pass through beat-aligned.
        do_reset();
        begin
            beat_t b;
            b = '0;
            b.strb = 4'b0111;
            b.keep = 4'b0111;
            b.id   = 4'd5;
            b.dest = 2'd2;
            b.data = 32'h3000_0001; b.user = 4'hA; b.last = 1'b0; push(3, b);
            b.data = 32'h3000_0002; b.user = 4'h5; b.last = 1'b0; push(3, b);
            b.data = 32'h3000_0003; b.user = 4'h3; b.last = 1'b1; push(3, b);
        end
        wait_out(3, 20, "t6_beats");
        tick();
        exp_d = '{32'h3000_0001, 32'h3000_0002, 32'h3000_0003, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        check_data("t6_data", 3);
        for (int i = 0; i < 3; i++) begin
            chk("t6_tid", 64'(out_log[i].id), 64'd5);
            chk("t6_tdest", 64'(out_log[i].dest), 64'd2);
            chk("t6_tkeep", 64'(out_log[i].keep), 64'h7);
            chk("t6_tstrb", 64'(out_log[i].strb), 64'h7);
            chk("t6_tlast", 64'(out_log[i].last), (i == 2) ? 64'd1 : 64'd0);
        end
        chk("t6_tuser0", 64'(out_log[0].user), 64'hA);
        chk("t6_tuser1", 64'(out_log[1].user), 64'h5);
        chk("t6_tuser2", 64'(out_log[2].user), 64'h3);
        exp_g = '{3, 0, 0, 0, 0, 0, 0, 0};
        check_grants("t6_grant", 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_packet_arbiter.md
Name: axis_packet_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one AXI4-Stream datapath (e.g. a single axis_width_converter feeding the USB3.0 FIFO path) between NUM_S upstream sources.
- Holds a grant from the first beat of a packet to the tlast beat, so packets are never interleaved.
- Runtime per-source enable mask lets firmware include or exclude sources.
- The data path is a zero-latency mux; only the grant decision is registered.

Parameters:
- NUM_S, 4, number of source ports (2-16).
- DATA_BYTES, 4, tdata width in bytes (1-512).
- TID_WIDTH, 1, tid width in bits (1-32).
- TDEST_WIDTH, 1, tdest width in bits (1-32).
- TUSER_WIDTH_PER_BYTE, 1, tuser bits per data byte (1-2048).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, asynchronous, active-low.
- s_enable  in  NUM_S  per-source arbitration enable; bit i=0 excludes source i from new grants.
- s_axis_tvalid  in  NUM_S  per-source valid.
- s_axis_tready  out  NUM_S  per-source ready.
- s_axis_tdata  in  NUM_S*DATA_BYTES*8  source i occupies slice i.
- s_axis_tstrb  in  NUM_S*DATA_BYTES  flattened, slice i.
- s_axis_tkeep  in  NUM_S*DATA_BYTES  flattened, slice i.
- s_axis_tlast  in  NUM_S  per-source last.
- s_axis_tid  in  NUM_S*TID_WIDTH  flattened.
- s_axis_tdest  in  NUM_S*TDEST_WIDTH  flattened.
- s_axis_tuser  in  NUM_S*DATA_BYTES*TUSER_WIDTH_PER_BYTE  flattened.
- m_axis_tvalid, m_axis_tready, m_axis_tdata, m_axis_tstrb, m_axis_tkeep, m_axis_tlast, m_axis_tid, m_axis_tdest, m_axis_tuser  out/in/out...  single-source widths  shared output stream.
- grant_idx  out  $clog2(NUM_S)  index of current owner; valid while grant_active=1.
- grant_active  out  1  high in BUSY state.
- pkt_done  out  1  one-cycle pulse after a tlast handshake on the output.

Behaviour:
- Reset values:
  - FSM=IDLE.
  - s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0.
  - grant_idx=0, grant_active=0, pkt_done=0.
  - last_grant=NUM_S-1, so source 0 has first priority.
- IDLE:
  - All s_axis_tready=0; m_axis_tvalid=0.
  - req = s_axis_tvalid & s_enable.
  - If req≠0, the registered winner is the first set bit of req searching from (last_grant+1) mod NUM_S upward with wrap-around.
  - grant_idx is loaded with the winner and the FSM moves to BUSY on the next edge.
  - If req=0, stay in IDLE.
- BUSY (grant g):
  - Output signals are driven combinationally from source g: m_axis_tvalid=s_axis_tvalid[g], all payload fields from slice g.
  - s_axis_tready[g]=m_axis_tready; all other s_axis_tready bits are 0.
  - On m_axis_tvalid&m_axis_tready&m_axis_tlast: last_grant<=g, pkt_done<=1 next cycle, FSM->IDLE.
- Latency:
  - 1 cycle from first tvalid in IDLE to output tvalid.
  - 1 mandatory idle cycle between packets, so the minimum packet-to-packet gap is 1 cycle.
  - Zero cycles through the data path.
- s_enable changes:
  - Sampled only in IDLE.
  - Deasserting s_enable[g] mid-packet does not revoke the grant; the packet completes.
- Source deasserts tvalid mid-packet: grant is held and the output shows tvalid=0 until the source resumes.
- Source drops tvalid between the IDLE decision and BUSY: grant is held until that source sends a packet ending in tlast. Sources must not withdraw valid per AXI-Stream rules.
- Single-beat packets (tlast on first beat): BUSY lasts one cycle when m_axis_tready=1.
- All sources disabled: remain in IDLE and stall every source.
- Reset mid-packet:
  - Immediate return to reset values; the partial packet is truncated downstream.
  - Upstream sources are responsible for flushing.
- Fairness: with K continuously requesting enabled sources, each gets exactly one packet per K grants.

Test Plan:
- Reset, then sources 0 and 2 both present 3-beat packets (tdata 0xA0..A2, 0xC0..C2), m_tready=1 -> output 0xA0,A1,A2 (tlast on A2), 1 idle cycle, then 0xC0,C1,C2; grant_idx 0 then 2; two pkt_done pulses.
- All 4 sources continuously request 1-beat packets -> grant order 0,1,2,3,0,1; output tvalid duty 50%.
- Source 1 granted, m_tready toggles 1,0,0,1 during a 4-beat packet -> no beat lost or duplicated; s_tready[1] mirrors m_tready; other sources' tready stay 0.
- s_enable=4'b1011 with all sources requesting -> source 2 never granted; clearing s_enable[0] mid-packet of source 0 lets that packet finish, then grant goes to 1.
- Assert aresetn=0 on beat 2 of a 5-beat packet -> next cycle m_tvalid=0, s_tready=0, grant_active=0; after release, source 0 wins first.
- Payload check: source 3 sends tid=5, tdest=2, tkeep=4'b0111, tuser pattern -> identical values appear on the output with the same beat alignment.
